// File: rtl/alu_fu.sv
// alu_fu: 8-bit one-cycle integer FU feeding an in-order result queue
// that requests the CDB via cdbreq/cdbgrant.
// Ports: clk, rst (sync, active-low); issue bus futransmit/operand/
// depvals/wbs/flag/robid; flush; fuready; CDB cdbreq/cdbgrant and
// head data cdbtag/cdbval/cdbwbs/cdbflag/cdbrobid; inflight count.
module alu_fu #(
    parameter int RQ_DEPTH = 2,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             futransmit,
    input  logic [7:0]       operand,
    input  logic [1:0][7:0]  depvals,
    input  logic [7:0]       wbs,
    input  logic [7:0]       flag,
    input  logic [7:0]       robid,
    input  logic             flush,
    output logic             fuready,
    output logic             cdbreq,
    input  logic             cdbgrant,
    output logic [TAG_W-1:0] cdbtag,
    output logic [7:0]       cdbval,
    output logic [7:0]       cdbwbs,
    output logic [7:0]       cdbflag,
    output logic [7:0]       cdbrobid,
    output logic [2:0]       inflight
);
    localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0] val;
        logic [7:0] wbs;
        logic [7:0] flg;
        logic [7:0] rid;
    } res_t;

    logic          e_v;
    logic [2:0]    e_op;
    logic          e_cin;
    logic [7:0]    e_a;
    logic [7:0]    e_b;
    logic [7:0]    e_wbs;
    logic [7:0]    e_rid;

    res_t          q [RQ_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;

    logic          acc;
    logic          push;
    logic          pop;
    res_t          res;
    res_t          head;

    // Only the op field, carry-enable and carry flag reach the ALU.
    logic unused_bits;
    assign unused_bits = ^{operand[7:5], operand[3], flag[7:1]};

    logic [8:0]  add;
    logic [8:0]  sub;
    logic [15:0] shl;
    logic [15:0] shr;
    logic [7:0]  r;
    logic        c;

    always_comb begin
        add = {1'b0, e_a} + {1'b0, e_b} + {8'd0, e_cin};
        // Bit 8 of the 9-bit difference is the borrow.
        sub = {1'b0, e_a} - {1'b0, e_b} - {8'd0, e_cin};
        // Widened shifts leave the last bit out next to the byte;
        // a zero shift leaves that bit clear.
        shl = {8'd0, e_a} << e_b[2:0];
        shr = {e_a, 8'd0} >> e_b[2:0];
        r   = 8'd0;
        c   = 1'b0;
        unique case (e_op)
            3'd0: {c, r} = add;
            3'd1: {c, r} = sub;
            3'd2: r = e_a & e_b;
            3'd3: r = e_a | e_b;
            3'd4: r = e_a ^ e_b;
            3'd5: begin
                r = shl[7:0];
                c = shl[8];
            end
            3'd6: begin
                r = shr[15:8];
                c = shr[7];
            end
            3'd7: r = e_a;
        endcase
    end

    assign res = '{
        val: r,
        wbs: e_wbs,
        flg: {5'd0, r[7], c, (r == 8'd0)},
        rid: e_rid
    };

    assign inflight = 3'(cnt) + {2'b00, e_v};
    assign fuready  = inflight < 3'(RQ_DEPTH);
    assign acc      = rst & ~flush & futransmit & fuready;
    assign push     = e_v;
    assign cdbreq   = cnt != '0;
    assign pop      = cdbreq & cdbgrant;
    assign head     = q[rp];

    assign cdbval   = cdbreq ? head.val : 8'd0;
    assign cdbwbs   = cdbreq ? head.wbs : 8'd0;
    assign cdbflag  = cdbreq ? head.flg : 8'd0;
    assign cdbrobid = cdbreq ? head.rid : 8'd0;
    assign cdbtag   = cdbreq ? head.rid[TAG_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            e_v <= 1'b0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            e_v <= acc;
            if (push)
                wp <= wp + PW'(1);
            if (pop)
                rp <= rp + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage; validity is carried by e_v and cnt.
    always_ff @(posedge clk) begin
        if (acc) begin
            e_op  <= operand[2:0];
            e_cin <= operand[4] & flag[0];
            e_a   <= depvals[0];
            e_b   <= depvals[1];
            e_wbs <= wbs;
            e_rid <= robid;
        end
        if (push)
            q[wp] <= res;
    end

endmodule

// File: tb/tb_alu_fu.sv
// tb_alu_fu: directed and random checks of alu_fu against a
// queue-based reference model.
module tb_alu_fu;
    localparam int D  = 2;
    localparam int TW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           futransmit = 1'b0;
    logic [7:0]     operand = 8'd0;
    logic [1:0][7:0] depvals = '0;
    logic [7:0]     wbs = 8'd0;
    logic [7:0]     flag = 8'd0;
    logic [7:0]     robid = 8'd0;
    logic           flush = 1'b0;
    logic           cdbgrant = 1'b0;
    logic           fuready;
    logic           cdbreq;
    logic [TW-1:0]  cdbtag;
    logic [7:0]     cdbval;
    logic [7:0]     cdbwbs;
    logic [7:0]     cdbflag;
    logic [7:0]     cdbrobid;
    logic [2:0]     inflight;

    alu_fu #(.RQ_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .futransmit(futransmit),
        .operand(operand), .depvals(depvals), .wbs(wbs),
        .flag(flag), .robid(robid), .flush(flush),
        .fuready(fuready), .cdbreq(cdbreq), .cdbgrant(cdbgrant),
        .cdbtag(cdbtag), .cdbval(cdbval), .cdbwbs(cdbwbs),
        .cdbflag(cdbflag), .cdbrobid(cdbrobid), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic [7:0] wbs;
        logic [7:0] flg;
        logic [7:0] rid;
        bit         rdy;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] bcast[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         maxinf  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t ref_op(input logic [7:0] op,
                                    input logic [7:0] a,
                                    input logic [7:0] b,
                                    input logic [7:0] fl,
                                    input logic [7:0] w,
                                    input logic [7:0] rid);
        ent_t e;
        int   s;
        int   sh;
        int   cin;
        bit   c;
        cin = (op[4] && fl[0]) ? 1 : 0;
        sh  = int'(b) % 8;
        c   = 1'b0;
        s   = 0;
        case (op[2:0])
            3'd0: begin s = int'(a) + int'(b) + cin; c = s > 255; end
            3'd1: begin s = int'(a) - int'(b) - cin; c = s < 0; end
            3'd2: s = int'(a & b);
            3'd3: s = int'(a | b);
            3'd4: s = int'(a ^ b);
            3'd5: begin
                s = int'(a) * (1 << sh);
                if (sh != 0) c = a[8 - sh];
            end
            3'd6: begin
                s = int'(a) / (1 << sh);
                if (sh != 0) c = a[sh - 1];
            end
            default: s = int'(a);
        endcase
        e.val = s[7:0];
        e.wbs = w;
        e.rid = rid;
        e.flg = {5'd0, e.val[7], c, e.val == 8'd0};
        e.rdy = 1'b0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [7:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] fl, input logic [7:0] w,
                         input logic [7:0] rid);
        futransmit = v;
        operand    = op;
        depvals[0] = a;
        depvals[1] = b;
        flag       = fl;
        wbs        = w;
        robid      = rid;
    endtask

    task automatic compare();
        bit   req;
        ent_t h;
        req = mq.size() > 0 && mq[0].rdy;
        chk("fuready", 64'(fuready), 64'(mq.size() < D));
        chk("cdbreq", 64'(cdbreq), 64'(req));
        chk("inflight", 64'(inflight), 64'(mq.size()));
        if (req) begin
            h = mq[0];
            chk("cdbdata",
                64'({cdbval, cdbwbs, cdbflag, cdbrobid, cdbtag}),
                64'({h.val, h.wbs, h.flg, h.rid, h.rid[TW-1:0]}));
        end else begin
            chk("cdbzero",
                64'({cdbval, cdbwbs, cdbflag, cdbrobid, cdbtag}),
                64'(0));
        end
    endtask

    // Inputs are set before the call; the model applies the edge.
    task automatic tick(output bit acc);
        bit   req_pre;
        ent_t e;
        req_pre = mq.size() > 0 && mq[0].rdy;
        acc = futransmit && (mq.size() < D) && !flush && rst;
        e = ref_op(operand, depvals[0], depvals[1], flag, wbs, robid);
        if (cdbreq && cdbgrant && rst && !flush)
            bcast.push_back(cdbrobid);
        @(posedge clk);
        if (!rst || flush) begin
            mq.delete();
        end else begin
            if (req_pre && cdbgrant)
                void'(mq.pop_front());
            foreach (mq[i]) mq[i].rdy = 1'b1;
            if (acc) mq.push_back(e);
        end
        @(negedge clk);
        if (int'(inflight) > maxinf) maxinf = int'(inflight);
        compare();
    endtask

    task automatic drain();
        bit a;
        futransmit = 1'b0;
        cdbgrant   = 1'b1;
        for (int i = 0; i < 20 && mq.size() > 0; i++) tick(a);
        chk("drain_inflight", 64'(inflight), 64'(0));
        cdbgrant = 1'b0;
    endtask

    initial begin
        bit a;
        int k;

        // Reset state
        rst = 1'b0;
        tick(a);
        tick(a);
        chk("rst_fuready", 64'(fuready), 64'(1));
        chk("rst_cdbreq", 64'(cdbreq), 64'(0));
        chk("rst_inflight", 64'(inflight), 64'(0));
        rst = 1'b1;
        tick(a);

        // ADD latency and hold
        drive(1, 8'h00, 8'h3C, 8'h05, 8'h00, 8'hBB, 8'h12);
        tick(a);
        futransmit = 1'b0;
        chk("add_e_stage", 64'(cdbreq), 64'(0));
        tick(a);
        chk("add_req", 64'(cdbreq), 64'(1));
        chk("add_val", 64'(cdbval), 64'(8'h41));
        chk("add_tag", 64'(cdbtag), 64'(4'h2));
        chk("add_rob", 64'(cdbrobid), 64'(8'h12));
        chk("add_wbs", 64'(cdbwbs), 64'(8'hBB));
        chk("add_flag", 64'(cdbflag), 64'(8'h00));
        tick(a);
        tick(a);
        chk("add_hold", 64'(cdbval), 64'(8'h41));
        cdbgrant = 1'b1;
        tick(a);
        cdbgrant = 1'b0;
        chk("add_pop", 64'(cdbreq), 64'(0));

        // SUB with borrow, then ADD carry-out to zero
        drive(1, 8'h11, 8'h05, 8'h05, 8'h01, 8'h01, 8'h13);
        tick(a);
        futransmit = 1'b0;
        tick(a);
        chk("sub_val", 64'(cdbval), 64'(8'hFF));
        chk("sub_flag", 64'(cdbflag), 64'(8'h06));
        drain();
        drive(1, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h02, 8'h14);
        tick(a);
        futransmit = 1'b0;
        tick(a);
        chk("addc_val", 64'(cdbval), 64'(8'h00));
        chk("addc_flag", 64'(cdbflag), 64'(8'h03));
        drain();

        // Backpressure
        bcast.delete();
        drive(1, 8'h03, 8'h10, 8'h01, 8'h00, 8'h00, 8'h01);
        tick(a);
        drive(1, 8'h04, 8'h10, 8'h01, 8'h00, 8'h00, 8'h02);
        tick(a);
        drive(1, 8'h05, 8'h10, 8'h01, 8'h00, 8'h00, 8'h03);
        chk("bp_full_rdy", 64'(fuready), 64'(0));
        chk("bp_full_inf", 64'(inflight), 64'(2));
        tick(a);
        chk("bp_held", 64'(inflight), 64'(2));
        cdbgrant = 1'b1;
        tick(a);
        cdbgrant = 1'b0;
        chk("bp_rdy_after", 64'(fuready), 64'(1));
        tick(a);
        futransmit = 1'b0;
        drain();
        chk("bp_count", 64'(bcast.size()), 64'(3));
        for (int i = 0; i < 3; i++)
            chk("bp_order", 64'(bcast[i]), 64'(i + 1));

        // Grant held, 8 ops streamed
        bcast.delete();
        maxinf = 0;
        cdbgrant = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 60 && (k < 8 || mq.size() > 0); cyc++) begin
            if (k < 8)
                drive(1, 8'($urandom_range(0, 31)), 8'($urandom),
                      8'($urandom), 8'($urandom), 8'($urandom),
                      8'(8'h20 + k));
            else
                futransmit = 1'b0;
            tick(a);
            if (a) k++;
        end
        futransmit = 1'b0;
        cdbgrant = 1'b0;
        chk("pp_count", 64'(bcast.size()), 64'(8));
        chk("pp_maxinf", 64'(maxinf <= D), 64'(1));
        for (int i = 0; i < 8; i++)
            chk("pp_order", 64'(bcast[i]), 64'(8'h20 + i));

        // Flush with E valid and a queued result
        bcast.delete();
        drive(1, 8'h02, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h31);
        tick(a);
        drive(1, 8'h07, 8'h55, 8'h00, 8'h00, 8'h00, 8'h32);
        tick(a);
        drive(1, 8'h04, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h33);
        flush = 1'b1;
        cdbgrant = 1'b1;
        tick(a);
        flush = 1'b0;
        cdbgrant = 1'b0;
        futransmit = 1'b0;
        chk("fl_req", 64'(cdbreq), 64'(0));
        chk("fl_inf", 64'(inflight), 64'(0));
        chk("fl_rdy", 64'(fuready), 64'(1));
        drive(1, 8'h05, 8'h81, 8'h01, 8'h00, 8'h00, 8'h34);
        tick(a);
        drain();
        chk("fl_count", 64'(bcast.size()), 64'(1));
        chk("fl_only_new", 64'(bcast[0]), 64'(8'h34));

        // Reset mid-operation
        bcast.delete();
        drive(1, 8'h06, 8'h81, 8'h01, 8'h00, 8'h00, 8'h41);
        tick(a);
        drive(1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h42);
        tick(a);
        rst = 1'b0;
        cdbgrant = 1'b1;
        tick(a);
        rst = 1'b1;
        cdbgrant = 1'b0;
        futransmit = 1'b0;
        chk("rm_req", 64'(cdbreq), 64'(0));
        chk("rm_inf", 64'(inflight), 64'(0));
        chk("rm_val", 64'({cdbval, cdbflag, cdbrobid}), 64'(0));
        drive(1, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h45);
        tick(a);
        futransmit = 1'b0;
        tick(a);
        chk("rm_new_val", 64'(cdbval), 64'(8'h03));
        drain();
        chk("rm_count", 64'(bcast.size()), 64'(1));

        // Random traffic
        for (int cyc = 0; cyc < 500; cyc++) begin
            rst      = $urandom_range(0, 59) != 0;
            flush    = $urandom_range(0, 24) == 0;
            cdbgrant = $urandom_range(0, 2) != 0;
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
            tick(a);
        end
        rst = 1'b1;
        flush = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
